// File: rtl/chebyshev_eval_if.sv
// Handshake/bus bundle for chebyshev_eval.
//  slave  : the evaluator (receives y/shift/lr and coefficient writes, presents results)
//  master : the producer/consumer side driving inputs and out_ready
// Signals:
//  in_valid/in_ready/in_y/in_shift/in_lr     : mantissa input handshake
//  coef_we/coef_addr/coef_wdata              : coefficient table write port
//  out_valid/out_ready/out_result/out_shift/
//  out_lr/out_zero/out_sat                   : result handshake
interface chebyshev_eval_if #(
  parameter int COEF_W = 18
);
  logic              in_valid;
  logic              in_ready;
  logic [17:0]       in_y;
  logic [3:0]        in_shift;
  logic              in_lr;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_result;
  logic [3:0]        out_shift;
  logic              out_lr;
  logic              out_zero;
  logic              out_sat;

  modport slave (
    input  in_valid, in_y, in_shift, in_lr, coef_we, coef_addr, coef_wdata, out_ready,
    output in_ready, out_valid, out_result, out_shift, out_lr, out_zero, out_sat
  );

  modport master (
    output in_valid, in_y, in_shift, in_lr, coef_we, coef_addr, coef_wdata, out_ready,
    input  in_ready, out_valid, out_result, out_shift, out_lr, out_zero, out_sat
  );
endinterface

// File: rtl/chebyshev_eval.sv
// Chebyshev series evaluator fed by the normalizer.
// Maps mantissa y in [0.5,1) (Q6.12, leading one at bit 11) to u = 4y-3 in [-1,1)
// and evaluates f(u) = sum c_k*T_k(u) with the Clenshaw recurrence, one
// coefficient per clock on a single multiplier. Shift/LR pass through for the
// downstream denormalize stage.
// Ports:
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset (aborts evaluation, clears coefficients)
//  bus  : chebyshev_eval_if.slave (input handshake, coefficient writes, result handshake)
module chebyshev_eval #(
  parameter int NCOEF  = 8,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 24
) (
  input logic               clk,
  input logic               rst,
  chebyshev_eval_if.slave   bus
);

  localparam int KW = $clog2(NCOEF);
  localparam int PW = ACC_W + 14;
  localparam int SW = ACC_W + 16;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

  state_t                    r_state, w_next;
  logic signed [COEF_W-1:0]  r_coef [NCOEF];
  logic signed [13:0]        r_u;
  logic signed [ACC_W-1:0]   r_b1, r_b2;
  logic [3:0]                r_k;
  logic [3:0]                r_shift;
  logic                      r_lr, r_zero, r_sat, r_out_valid;
  logic [COEF_W-1:0]         r_result;

  logic                      w_accept;
  logic                      w_coef_wr;
  logic [11:0]               w_diff;
  logic signed [13:0]        w_u;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW:0]        w_prod2;
  logic signed [SW-1:0]      w_term, w_sum;
  logic [SW-ACC_W:0]         w_hi_acc;
  logic [SW-COEF_W:0]        w_hi_res;
  logic                      w_ovf_acc, w_ovf_res;
  logic [ACC_W-1:0]          w_bsat;
  logic [COEF_W-1:0]         w_rsat;
  logic                      w_unused_y;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_coef_wr = bus.coef_we && ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                     ({1'b0, bus.coef_addr} < 5'(NCOEF));

  // u = 4*y - 3 in Q1.12: (y[11:0] - 0.75) scaled by 4
  assign w_diff     = bus.in_y[11:0] - 12'hC00;
  assign w_u        = {w_diff, 2'b00};
  assign w_unused_y = ^bus.in_y[17:12];

  assign w_prod  = PW'(r_u) * PW'(r_b1);
  assign w_prod2 = $signed({w_prod, 1'b0});
  assign w_term  = (r_state == S_ITER) ? SW'(w_prod2 >>> 12) : SW'(w_prod >>> 12);
  // r_k is 0 in FINAL, so the same read port supplies c0 there
  assign w_sum   = SW'(r_coef[r_k[KW-1:0]]) + w_term - SW'(r_b2);

  // Overflow when the bits above the target sign bit disagree
  assign w_hi_acc  = w_sum[SW-1:ACC_W-1];
  assign w_hi_res  = w_sum[SW-1:COEF_W-1];
  assign w_ovf_acc = !((&w_hi_acc) || !(|w_hi_acc));
  assign w_ovf_res = !((&w_hi_res) || !(|w_hi_res));
  assign w_bsat    = w_ovf_acc ? {w_sum[SW-1], {(ACC_W-1){~w_sum[SW-1]}}}  : w_sum[ACC_W-1:0];
  assign w_rsat    = w_ovf_res ? {w_sum[SW-1], {(COEF_W-1){~w_sum[SW-1]}}} : w_sum[COEF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = bus.in_y[11] ? S_ITER : S_DONE;
      S_ITER:  if (r_k == 4'd1) w_next = S_FINAL;
      S_FINAL: w_next = S_DONE;
      S_DONE:  if (r_out_valid && bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCOEF; i++) r_coef[i] <= '0;
      r_u         <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_k         <= '0;
      r_shift     <= '0;
      r_lr        <= 1'b0;
      r_zero      <= 1'b0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      // A write in the accept cycle lands before ITER first reads the table,
      // so the new coefficient is the one used.
      if (w_coef_wr) r_coef[bus.coef_addr[KW-1:0]] <= bus.coef_wdata;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift  <= bus.in_shift;
            r_lr     <= bus.in_lr;
            r_zero   <= ~bus.in_y[11];
            r_u      <= w_u;
            r_b1     <= '0;
            r_b2     <= '0;
            r_k      <= 4'(NCOEF - 1);
            r_sat    <= 1'b0;
            r_result <= '0;
          end
        end
        S_ITER: begin
          r_b2 <= r_b1;
          r_b1 <= w_bsat;
          r_k  <= r_k - 4'd1;
          if (w_ovf_acc) r_sat <= 1'b1;
        end
        S_FINAL: begin
          r_result <= w_rsat;
          if (w_ovf_res) r_sat <= 1'b1;
        end
        S_DONE: begin
          if (!r_out_valid)        r_out_valid <= 1'b1;
          else if (bus.out_ready)  r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_result;
  assign bus.out_shift  = r_shift;
  assign bus.out_lr     = r_lr;
  assign bus.out_zero   = r_zero;
  assign bus.out_sat    = r_sat;

endmodule

// File: tb/tb_chebyshev_eval.sv
module tb_chebyshev_eval;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chebyshev_eval_if #(.COEF_W(18)) bus ();

  chebyshev_eval #(.NCOEF(8), .COEF_W(18), .ACC_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [17:0] res;
    logic [3:0]  sh;
    logic        lr;
    logic        zero;
    logic        sat;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_exp, m_snap;
  logic        m_seen = 1'b0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on the first valid cycle, then checks hold-stability
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!m_seen) begin
        m_seen = 1'b1;
        if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          m_exp = sb.pop_front();
          chk("result",  32'(bus.out_result), 32'(m_exp.res));
          chk("shift",   32'(bus.out_shift),  32'(m_exp.sh));
          chk("lr",      32'(bus.out_lr),     32'(m_exp.lr));
          chk("zero",    32'(bus.out_zero),   32'(m_exp.zero));
          chk("sat",     32'(bus.out_sat),    32'(m_exp.sat));
          chk("latency", cyc - accept_cyc,    m_exp.lat);
        end
        m_snap.res  = bus.out_result;
        m_snap.sh   = bus.out_shift;
        m_snap.lr   = bus.out_lr;
        m_snap.zero = bus.out_zero;
        m_snap.sat  = bus.out_sat;
      end else begin
        chk("stable_result", 32'(bus.out_result), 32'(m_snap.res));
        chk("stable_shift",  32'(bus.out_shift),  32'(m_snap.sh));
        chk("stable_zero",   32'(bus.out_zero),   32'(m_snap.zero));
        chk("stable_sat",    32'(bus.out_sat),    32'(m_snap.sat));
      end
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_ready) begin
        m_seen = 1'b0;
        done_cnt++;
      end
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic write_coef(input logic [3:0] a, input logic [17:0] d);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = a;
    bus.coef_wdata = d;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic run_eval(input logic [17:0] y, input logic [3:0] sh, input logic lr,
                          input logic wen, input logic [3:0] wa, input logic [17:0] wd,
                          input int hold, input logic mid_wr,
                          input logic [17:0] e_res, input logic e_zero, input logic e_sat,
                          input int unsigned e_lat);
    int   start;
    exp_t x;
    start = done_cnt;
    for (int i = 0; i < 50 && !bus.in_ready; i++) begin @(posedge clk); #1; end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_y       = y;
    bus.in_shift   = sh;
    bus.in_lr      = lr;
    bus.coef_we    = wen;
    bus.coef_addr  = wa;
    bus.coef_wdata = wd;
    if (hold > 0) bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    accept_cyc   = cyc;
    x.res = e_res; x.sh = sh; x.lr = lr; x.zero = e_zero; x.sat = e_sat; x.lat = e_lat;
    sb.push_back(x);
    if (mid_wr) begin
      @(posedge clk); #1;
      bus.coef_we    = 1'b1;
      bus.coef_addr  = 4'd1;
      bus.coef_wdata = 18'h00000;
      @(posedge clk); #1;
      bus.coef_we = 1'b0;
    end
    if (hold > 0) begin
      for (int i = 0; i < 50 && !bus.out_valid; i++) begin @(posedge clk); #1; end
      repeat (hold) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 60 && done_cnt == start; i++) begin @(posedge clk); #1; end
    if (done_cnt == start) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_y = '0; bus.in_shift = '0; bus.in_lr = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
    chk("rst_result",    32'(bus.out_result), 32'd0);
    chk("rst_shift",     32'(bus.out_shift),  32'd0);
    chk("rst_lr",        32'(bus.out_lr),     32'd0);
    chk("rst_zero",      32'(bus.out_zero),   32'd0);
    chk("rst_sat",       32'(bus.out_sat),    32'd0);

    // Constant term only
    write_coef(4'd0, 18'h04000);
    run_eval(18'h00A3C, 4'h5, 1'b1, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h04000, 1'b0, 1'b0, 9);

    // f = T1(u) = u
    write_coef(4'd0, 18'h00000);
    write_coef(4'd1, 18'h08000);
    run_eval(18'h00C00, 4'h3, 1'b0, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h00000, 1'b0, 1'b0, 9);
    run_eval(18'h00E00, 4'hA, 1'b1, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h04000, 1'b0, 1'b0, 9);

    // f = T2(u), T2(0.5) = -0.5
    write_coef(4'd1, 18'h00000);
    write_coef(4'd2, 18'h08000);
    run_eval(18'h00E00, 4'h1, 1'b0, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h3C000, 1'b0, 1'b0, 9);

    // Saturation near u = 1
    for (int i = 0; i < 8; i++) write_coef(4'(i), 18'h1FFFF);
    run_eval(18'h00FFF, 4'hF, 1'b1, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h1FFFF, 1'b0, 1'b1, 9);

    // Zero mantissa with 5 cycles of backpressure
    run_eval(18'h00000, 4'h0, 1'b0, 1'b0, 4'd0, 18'h0, 5, 1'b0, 18'h00000, 1'b1, 1'b0, 1);

    // Coefficient write during ITER is ignored
    for (int i = 0; i < 8; i++) write_coef(4'(i), 18'h00000);
    write_coef(4'd1, 18'h08000);
    run_eval(18'h00E00, 4'h2, 1'b0, 1'b0, 4'd0, 18'h0, 0, 1'b1, 18'h04000, 1'b0, 1'b0, 9);
    run_eval(18'h00E00, 4'h6, 1'b1, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h04000, 1'b0, 1'b0, 9);

    // Reset in the third iteration aborts and clears coefficients
    bus.in_valid = 1'b1; bus.in_y = 18'h00E00; bus.in_shift = 4'h7; bus.in_lr = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_shift",     32'(bus.out_shift), 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_eval(18'h00E00, 4'h4, 1'b0, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h00000, 1'b0, 1'b0, 9);

    // Write and accept in the same cycle: new c0 is used
    run_eval(18'h00C00, 4'h9, 1'b1, 1'b1, 4'd0, 18'h02000, 0, 1'b0, 18'h02000, 1'b0, 1'b0, 9);

    // Out-of-range address is ignored (would alias c0 if decoded short)
    write_coef(4'd8, 18'h01111);
    run_eval(18'h00C00, 4'hC, 1'b0, 1'b0, 4'd0, 18'h0, 0, 1'b0, 18'h02000, 1'b0, 1'b0, 9);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
